diff_accum: RTL and testbench

Downstream consumer of the signed add/subtract stage. It takes a stream of signed differences (diff_axb style, 9-bit) over a valid/ready handshake and accumulates them into a wider signed sum. After every BLOCK_LEN accepted samples it emits one block result with a sticky overflow flag, and holds that result under output backpressure.

---
 rtl/diff_accum_pkg.sv | 14 +
 rtl/diff_accum_if.sv | 26 ++
 rtl/diff_accum_add.sv | 29 ++
 rtl/diff_accum.sv | 90 +++++++++
 tb/tb_diff_accum.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/diff_accum_pkg.sv
// Shared types and saturation helpers for the diff_accum block.
package diff_accum_pkg;

    typedef enum logic {ACCUM, HOLD} state_t;

    function automatic logic signed [63:0] sat_max(int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/diff_accum_if.sv
// Sample-in / block-result-out handshake bundle for diff_accum.
interface diff_accum_if #(
    parameter int DIFF_W    = 9,
    parameter int ACC_W     = 16,
    parameter int BLOCK_LEN = 4,
    localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [DIFF_W-1:0] in_diff;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_cnt;

    modport master (
        output in_valid, in_diff, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_cnt
    );

    modport slave (
        input  in_valid, in_diff, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_cnt
    );
endinterface

// File: rtl/diff_accum_add.sv
// Sign-extending accumulate step with overflow detect.
// DIFF_ACCUM_SAT_EN defined: clamp on overflow; undefined: two's-complement wrap.
module diff_accum_add
    import diff_accum_pkg::*;
#(
    parameter int DIFF_W = 9,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DIFF_W-1:0] in_diff,
    output logic [ACC_W-1:0]  acc_next,
    output logic              ovf
);
    logic [ACC_W:0] sum;

    always_comb begin
        sum = {acc[ACC_W-1], acc}
            + {{(ACC_W + 1 - DIFF_W){in_diff[DIFF_W-1]}}, in_diff};
        ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef DIFF_ACCUM_SAT_EN
        if (ovf)
            acc_next = sum[ACC_W] ? ACC_W'(sat_min(ACC_W)) : ACC_W'(sat_max(ACC_W));
        else
            acc_next = sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/diff_accum.sv
// Accumulates BLOCK_LEN signed differences per block and holds each block result
// (with sticky overflow) until downstream accepts it. Option: DIFF_ACCUM_SAT_EN.
module diff_accum
    import diff_accum_pkg::*;
#(
    parameter int DIFF_W    = 9,
    parameter int ACC_W     = 16,
    parameter int BLOCK_LEN = 4,
    localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    diff_accum_if.slave  bus
);
    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             ovf_sticky;
    logic             step_ovf;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic             out_ovf_q;
    logic [CNT_W-1:0] out_cnt_q;

    diff_accum_add #(
        .DIFF_W (DIFF_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc      (acc),
        .in_diff  (bus.in_diff),
        .acc_next (acc_next),
        .ovf      (step_ovf)
    );

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_cnt   = out_cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            ovf_sticky  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else if (clr) begin
            // result registers deliberately keep their last values
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            ovf_sticky  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (cnt == CNT_W'(BLOCK_LEN - 1)) begin
                            out_sum_q   <= acc_next;
                            out_ovf_q   <= ovf_sticky | step_ovf;
                            out_cnt_q   <= CNT_W'(BLOCK_LEN);
                            out_valid_q <= 1'b1;
                            acc         <= '0;
                            cnt         <= '0;
                            ovf_sticky  <= 1'b0;
                            state       <= HOLD;
                        end else begin
                            acc        <= acc_next;
                            cnt        <= cnt + 1'b1;
                            ovf_sticky <= ovf_sticky | step_ovf;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_diff_accum.sv
// Directed bench for diff_accum: default build plus a narrow ACC_W=8 instance for overflow cases.
module tb_diff_accum;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic clr = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    diff_accum_if #(.DIFF_W(9), .ACC_W(16), .BLOCK_LEN(4)) b16 ();
    diff_accum_if #(.DIFF_W(8), .ACC_W(8),  .BLOCK_LEN(4)) b8 ();

    diff_accum #(.DIFF_W(9), .ACC_W(16), .BLOCK_LEN(4)) u_dut16 (
        .clk (clk), .rst_b (rst_b), .clr (clr), .bus (b16.slave)
    );
    diff_accum #(.DIFF_W(8), .ACC_W(8), .BLOCK_LEN(4)) u_dut8 (
        .clk (clk), .rst_b (rst_b), .clr (1'b0), .bus (b8.slave)
    );

`ifdef DIFF_ACCUM_SAT_EN
    localparam int EXP_POS = 107;
    localparam int EXP_NEG = -78;
`else
    localparam int EXP_POS = -36;
    localparam int EXP_NEG = 106;
`endif

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send16(input int d);
        int n;
        n = 0;
        b16.in_valid = 1'b1;
        b16.in_diff  = 9'(d);
        while (!b16.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("send16_timeout", 32'(b16.in_ready), 1);
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
    endtask

    task automatic send8(input int d);
        int n;
        n = 0;
        b8.in_valid = 1'b1;
        b8.in_diff  = 8'(d);
        while (!b8.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("send8_timeout", 32'(b8.in_ready), 1);
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
    endtask

    initial begin
        b16.in_valid = 1'b0; b16.in_diff = '0; b16.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.in_diff  = '0; b8.out_ready  = 1'b1;

        // reset state
        #12;
        check("rst_out_valid", b16.out_valid, 0);
        check("rst_out_sum", $signed(b16.out_sum), 0);
        check("rst_out_ovf", b16.out_ovf, 0);
        check("rst_out_cnt", b16.out_cnt, 0);
        check("rst_in_ready", b16.in_ready, 1);
        #10 rst_b = 1'b1;
        @(posedge clk); #1;

        // basic block
        send16(0); send16(26); send16(-41); send16(120);
        check("basic_valid", b16.out_valid, 1);
        check("basic_sum", $signed(b16.out_sum), 105);
        check("basic_ovf", b16.out_ovf, 0);
        check("basic_cnt", b16.out_cnt, 4);
        check("basic_hold_ready", b16.in_ready, 0);
        @(posedge clk); #1;
        check("basic_valid_drop", b16.out_valid, 0);
        check("basic_ready_back", b16.in_ready, 1);

        // backpressure, with in_valid asserted during HOLD to show it is ignored
        b16.out_ready = 1'b0;
        send16(0); send16(26); send16(-41); send16(120);
        b16.in_valid = 1'b1; b16.in_diff = 9'(99);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", b16.out_valid, 1);
            check("bp_sum", $signed(b16.out_sum), 105);
            check("bp_ready", b16.in_ready, 0);
            @(posedge clk); #1;
        end
        b16.in_valid = 1'b0;
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_accept_valid", b16.out_valid, 0);
        check("bp_accept_ready", b16.in_ready, 1);

        // positive and negative overflow on narrow instance
        send8(120); send8(120); send8(-10); send8(-10);
        check("povf_sum", $signed(b8.out_sum), EXP_POS);
        check("povf_ovf", b8.out_ovf, 1);
        send8(-100); send8(-100); send8(50); send8(0);
        check("novf_sum", $signed(b8.out_sum), EXP_NEG);
        check("novf_ovf", b8.out_ovf, 1);
        send8(1); send8(1); send8(1); send8(1);
        check("sticky_clr_sum", $signed(b8.out_sum), 4);
        check("sticky_clr_ovf", b8.out_ovf, 0);
        @(posedge clk); #1;

        // clr mid-block: concurrent transfer ignored, result registers retained
        send16(5); send16(7);
        b16.in_valid = 1'b1; b16.in_diff = 9'(50);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; b16.in_valid = 1'b0;
        check("clr_valid", b16.out_valid, 0);
        check("clr_ready", b16.in_ready, 1);
        check("clr_sum_kept", $signed(b16.out_sum), 105);
        send16(1); send16(1); send16(1); send16(1);
        check("clr_block_valid", b16.out_valid, 1);
        check("clr_block_sum", $signed(b16.out_sum), 4);
        check("clr_block_ovf", b16.out_ovf, 0);
        @(posedge clk); #1;

        // reset while holding a result
        b16.out_ready = 1'b0;
        send16(1); send16(2); send16(3); send16(4);
        check("pre_rst_sum", $signed(b16.out_sum), 10);
        #2 rst_b = 1'b0;
        #1;
        check("hold_rst_valid", b16.out_valid, 0);
        check("hold_rst_sum", $signed(b16.out_sum), 0);
        check("hold_rst_ready", b16.in_ready, 1);
        #1 rst_b = 1'b1;
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        send16(2); send16(2); send16(2); send16(-3);
        check("post_rst_sum", $signed(b16.out_sum), 3);
        check("post_rst_cnt", b16.out_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
